// File: rtl/tof_event_buffer_pkg.sv
// tof_event_buffer_pkg: shared defaults and filter state encoding
package tof_event_buffer_pkg;
    localparam int NP_DEF      = 10;
    localparam int DEPTH_DEF   = 8;
    localparam int TOF_MAX_DEF = 1000;
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, SPENT = 2'd2} state_t;
endpackage

// File: rtl/tof_event_buffer_sync_fifo.sv
// tof_event_buffer_sync_fifo: synchronous FIFO storage with occupancy level
module tof_event_buffer_sync_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         res,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [AW:0]  level
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    assign head = mem[rptr];
    // storage array, no reset needed
    always_ff @(posedge clk)
        if (push) mem[wptr] <= din;
    // pointers wrap naturally at DEPTH; level has one extra bit to tell full from empty
    always_ff @(posedge clk)
        if (res) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= push ? wptr + 1'b1 : wptr;
            rptr  <= pop ? rptr + 1'b1 : rptr;
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
endmodule

// File: rtl/tof_event_buffer.sv
// tof_event_buffer: first-photon filter feeding a FIFO toward the histogram stage
module tof_event_buffer
    import tof_event_buffer_pkg::*;
#(
    parameter int NP      = NP_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TOF_MAX = TOF_MAX_DEF,
    localparam int LW     = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          res,
    input  logic          laser_sync,
    input  logic          tdc_valid,
    input  logic [NP-1:0] tdc_code,
    input  logic          hold,
    output logic [NP-1:0] roughData,
    output logic          wrEn,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic [15:0]   drop_cnt
);
    localparam logic [NP-1:0] TMAX = NP'(TOF_MAX);
    state_t        state;
    logic [NP-1:0] head;
    logic          pop;
    logic          armed_ok;
    logic          in_range;
    logic          space_ok;
    logic          push;
    logic          reject;
    assign pop      = (level != '0) && !hold;
    assign armed_ok = (state == ARMED) || laser_sync;
    assign in_range = (tdc_code != '0) && (tdc_code <= TMAX);
    assign space_ok = (level != LW'(DEPTH)) || pop;
    assign push     = tdc_valid && armed_ok && in_range && space_ok && !res;
    assign reject   = tdc_valid && !(armed_ok && in_range && space_ok);
    tof_event_buffer_sync_fifo #(.W(NP), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (push),
        .pop   (pop && !res),
        .din   (tdc_code),
        .head  (head),
        .level (level)
    );
    // filter FSM: an accepted photon spends the period, laser_sync re-arms
    always_ff @(posedge clk)
        if (res) state <= IDLE;
        else state <= push ? SPENT : laser_sync ? ARMED : state;
    // output register holds its last value between pops
    always_ff @(posedge clk)
        if (res) begin
            roughData <= '0;
            wrEn      <= 1'b0;
        end else begin
            roughData <= pop ? head : roughData;
            wrEn      <= pop;
        end
    // drop statistics: saturating reject count and sticky full-loss flag
    always_ff @(posedge clk)
        if (res) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            drop_cnt <= drop_cnt + ((reject && drop_cnt != 16'hFFFF) ? 16'd1 : 16'd0);
            overflow <= overflow | (tdc_valid && armed_ok && in_range && !space_ok);
        end
endmodule

// File: tb/tb_tof_event_buffer.sv
// tb_tof_event_buffer: directed scenarios with a scoreboard on the wrEn stream
module tb_tof_event_buffer;
    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        laser_sync = 1'b0;
    logic        tdc_valid = 1'b0;
    logic [9:0]  tdc_code = '0;
    logic        hold = 1'b0;
    logic [9:0]  roughData;
    logic        wrEn;
    logic [3:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;
    int          checks = 0;
    int          failures = 0;
    int          pulses = 0;
    logic [9:0]  exp_q[$];

    tof_event_buffer dut (
        .clk        (clk),
        .res        (res),
        .laser_sync (laser_sync),
        .tdc_valid  (tdc_valid),
        .tdc_code   (tdc_code),
        .hold       (hold),
        .roughData  (roughData),
        .wrEn       (wrEn),
        .level      (level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        res = 1'b1;
        laser_sync = 1'b0;
        tdc_valid = 1'b0;
        hold = 1'b0;
        idle(2);
        res = 1'b0;
    endtask

    task automatic sync();
        laser_sync = 1'b1;
        cyc();
        laser_sync = 1'b0;
    endtask

    task automatic ev(input logic [9:0] code, input logic ls);
        laser_sync = ls;
        tdc_valid = 1'b1;
        tdc_code = code;
        cyc();
        laser_sync = 1'b0;
        tdc_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        fork
            forever begin
                @(negedge clk);
                if (wrEn) begin
                    pulses++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_wrEn got=%0d exp=none", roughData);
                    end else begin
                        logic [9:0] e;
                        e = exp_q.pop_front();
                        if (roughData !== e) begin
                            failures++;
                            $display("FAIL scoreboard_data got=%0d exp=%0d", roughData, e);
                        end
                    end
                end
            end
        join_none
        do_reset();
        chk("rst_level", level, 0);
        chk("rst_wrEn", wrEn, 0);
        chk("rst_roughData", roughData, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        ev(10'd50, 1'b0);
        idle(2);
        chk("idle_drop", drop_cnt, 1);
        chk("idle_level", level, 0);

        do_reset();
        sync();
        exp_q.push_back(10'd108);
        ev(10'd108, 1'b0);
        chk("s34_level_after_write", level, 1);
        chk("s34_wrEn_early", wrEn, 0);
        cyc();
        chk("s34_wrEn_latency", wrEn, 1);
        chk("s34_data", roughData, 108);
        ev(10'd511, 1'b0);
        idle(3);
        chk("s34_drop", drop_cnt, 1);
        chk("s34_hold_data", roughData, 108);

        do_reset();
        sync();
        ev(10'd0, 1'b0);
        sync();
        ev(10'd1023, 1'b0);
        sync();
        exp_q.push_back(10'd1000);
        ev(10'd1000, 1'b0);
        idle(4);
        chk("s35_drop", drop_cnt, 2);
        chk("s35_overflow", overflow, 0);

        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sync();
            exp_q.push_back(10'd90);
            ev(10'd90, 1'b0);
        end
        chk("s36_level_full", level, 8);
        chk("s36_no_ovf_yet", overflow, 0);
        sync();
        ev(10'd90, 1'b0);
        chk("s36_level_still_full", level, 8);
        chk("s36_overflow", overflow, 1);
        chk("s36_drop", drop_cnt, 1);
        chk("s36_wrEn_held", wrEn, 0);
        pulses = 0;
        hold = 1'b0;
        idle(12);
        chk("s36_pulses", pulses, 8);
        chk("s36_level_empty", level, 0);
        chk("s36_overflow_sticky", overflow, 1);

        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sync();
            exp_q.push_back(10'(10 + i));
            ev(10'(10 + i), 1'b0);
        end
        chk("s37_level_full", level, 8);
        hold = 1'b0;
        exp_q.push_back(10'd500);
        ev(10'd500, 1'b1);
        chk("s37_level_kept", level, 8);
        chk("s37_overflow", overflow, 0);
        chk("s37_first_out", roughData, 10);
        idle(12);
        chk("s37_level_empty", level, 0);
        chk("s37_drop", drop_cnt, 0);

        do_reset();
        exp_q.push_back(10'd700);
        ev(10'd700, 1'b1);
        ev(10'd701, 1'b0);
        idle(3);
        chk("s38_drop", drop_cnt, 1);
        chk("s38_level", level, 0);

        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sync();
            ev(10'(200 + i), 1'b0);
        end
        chk("s39_level_pre", level, 5);
        res = 1'b1;
        tdc_valid = 1'b1;
        tdc_code = 10'd300;
        cyc();
        res = 1'b0;
        tdc_valid = 1'b0;
        hold = 1'b0;
        chk("s39_level", level, 0);
        chk("s39_wrEn", wrEn, 0);
        chk("s39_drop", drop_cnt, 0);
        ev(10'd400, 1'b0);
        idle(3);
        chk("s39_drop_before_sync", drop_cnt, 1);
        chk("s39_level_before_sync", level, 0);
        sync();
        exp_q.push_back(10'd401);
        ev(10'd401, 1'b0);
        idle(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
